// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receive-capture state encoding
package uart_pkg;

    typedef enum logic [1:0] {
        WAIT_RS  = 2'b00,
        ACK      = 2'b01,
        WAIT_CLR = 2'b10
    } cap_state_t;

    localparam int DEFAULT_DEPTH = 16;
    localparam int OVERSAMPLE    = 16;
    localparam int HALF_BIT      = OVERSAMPLE / 2;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer, resets to 0
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte capture handshake into a FWFT FIFO with status and irq
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_rs,
    output logic          rx_over_read,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    input  logic          clr,
    input  logic [AW:0]   irq_level,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overrun,
    output logic          irq
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic             rs_s;
    cap_state_t       state;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [7:0]       mem [DEPTH];
    logic             push_req;
    logic             push;
    logic             pop;
    logic             drop;

    sync_2ff u_rs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_rs),
        .q     (rs_s)
    );

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // A full FIFO still accepts the byte if the reader frees a slot on the same edge.
    assign push_req = (state == WAIT_RS) && rs_s;
    assign pop      = rd_en && !empty;
    assign push     = push_req && (!full || rd_en);
    assign drop     = push_req && full && !rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_RS;
            rx_over_read <= 1'b0;
        end else begin
            case (state)
                WAIT_RS: begin
                    if (rs_s) begin
                        state        <= ACK;
                        rx_over_read <= 1'b1;
                    end
                end
                ACK: begin
                    state        <= WAIT_CLR;
                    rx_over_read <= 1'b0;
                end
                WAIT_CLR: begin
                    if (!rs_s) state <= WAIT_RS;
                end
                default: begin
                    state        <= WAIT_RS;
                    rx_over_read <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= ((irq_level != '0) && (count >= irq_level)) || overrun;
    end

    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_rs;
    logic       rx_over_read;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       clr;
    logic [4:0] irq_level;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overrun;
    logic       irq;

    int tests = 0;
    int fails = 0;

    logic [7:0] q[$];
    bit         ovr_m;
    bit         irq_m;

    typedef struct {
        int lvl;
        int n;
        int exp_count;
        bit exp_irq;
    } thr_vec_t;

    thr_vec_t tv[7];

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_rs        (rx_rs),
        .rx_over_read (rx_over_read),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .clr          (clr),
        .irq_level    (irq_level),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overrun      (overrun),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ovr_m = 1'b0;
        irq_m = 1'b0;
    endtask

    // One clock: update the reference model at the rising edge, compare at the falling edge.
    task automatic tick(input bit push_edge);
        bit irq_n;
        bit full_m;
        bit popping;
        bit pushing;
        @(posedge clk);
        irq_n = ((irq_level != 0) && (q.size() >= int'(irq_level))) || ovr_m;
        if (clr) begin
            q.delete();
            ovr_m = 1'b0;
        end else begin
            full_m  = (q.size() == DEPTH);
            popping = rd_en && (q.size() > 0);
            pushing = push_edge && (!full_m || rd_en);
            if (popping) void'(q.pop_front());
            if (pushing) q.push_back(rx_data);
            if (push_edge && full_m && !rd_en) ovr_m = 1'b1;
        end
        irq_m = irq_n;
        @(negedge clk);
        chk("count",        32'(count),        32'(q.size()));
        chk("empty",        32'(empty),        32'(q.size() == 0));
        chk("full",         32'(full),         32'(q.size() == DEPTH));
        chk("overrun",      32'(overrun),      32'(ovr_m));
        chk("irq",          32'(irq),          32'(irq_m));
        chk("rx_over_read", 32'(rx_over_read), 32'(push_edge));
        chk("rd_data",      32'(rd_data),      32'(q.size() > 0 ? q[0] : 8'h00));
    endtask

    // Receiver handshake: rs raised before E1, push on E3, rs dropped once acknowledged.
    task automatic capture(input logic [7:0] d, input bit rdp, input bit clp, input bit rnd);
        rx_data = d;
        rx_rs   = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            rd_en = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
            clr   = 1'b0;
            if (k == 3) begin
                rd_en = rdp;
                clr   = clp;
            end
            if (k == 5) rx_rs = 1'b0;
            tick(k == 3);
        end
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick(1'b0);
        clr = 1'b0;
    endtask

    initial begin
        tv[0] = '{4, 3, 3, 1'b0};
        tv[1] = '{4, 4, 4, 1'b1};
        tv[2] = '{0, 6, 6, 1'b0};
        tv[3] = '{1, 1, 1, 1'b1};
        tv[4] = '{16, 16, 16, 1'b1};
        tv[5] = '{15, 14, 14, 1'b0};
        tv[6] = '{2, 0, 0, 1'b0};

        rst_n = 1'b0; rx_data = 8'h00; rx_rs = 1'b0; rd_en = 1'b0;
        clr = 1'b0; irq_level = 5'd0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_over_read", 32'(rx_over_read), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'h00);
        rst_n = 1'b1;

        // Single byte
        capture(8'hA5, 1'b0, 1'b0, 1'b0);
        chk("single_count", 32'(count), 32'd1);
        chk("single_data", 32'(rd_data), 32'hA5);
        chk("single_empty", 32'(empty), 32'd0);

        // Fill to full, then overrun with the 17th byte
        do_clear();
        for (int i = 0; i < 17; i++) capture(8'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_overrun", 32'(overrun), 32'd1);
        chk("fill_irq", 32'(irq), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", 32'(rd_data), 32'(i));
            rd_en = 1'b1;
            tick(1'b0);
        end
        rd_en = 1'b0;
        chk("drain_empty", 32'(empty), 32'd1);

        // Push with pop while full, pointers offset so the write wraps
        do_clear();
        for (int i = 0; i < 5; i++) capture(8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        rd_en = 1'b1;
        repeat (5) tick(1'b0);
        rd_en = 1'b0;
        for (int i = 0; i < 16; i++) capture(8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) capture(8'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
        chk("pp_count", 32'(count), 32'd16);
        chk("pp_overrun", 32'(overrun), 32'd0);
        chk("pp_head", 32'(rd_data), 32'h84);
        rd_en = 1'b1;
        repeat (16) tick(1'b0);
        rd_en = 1'b0;

        // Threshold interrupt table
        for (int v = 0; v < 7; v++) begin
            do_clear();
            irq_level = 5'(tv[v].lvl);
            for (int i = 0; i < tv[v].n; i++) capture(8'($urandom), 1'b0, 1'b0, 1'b0);
            tick(1'b0);
            chk("thr_count", 32'(count), 32'(tv[v].exp_count));
            chk("thr_irq", 32'(irq), 32'(tv[v].exp_irq));
        end

        // irq falls one cycle after the count drops below the threshold
        do_clear();
        irq_level = 5'd4;
        for (int i = 0; i < 4; i++) capture(8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        chk("thr4_irq_hi", 32'(irq), 32'd1);
        rd_en = 1'b1;
        tick(1'b0);
        rd_en = 1'b0;
        chk("thr4_count3", 32'(count), 32'd3);
        chk("thr4_irq_lag", 32'(irq), 32'd1);
        tick(1'b0);
        chk("thr4_irq_lo", 32'(irq), 32'd0);
        irq_level = 5'd0;

        // Read on empty, then clr colliding with a push while overrun is set
        do_clear();
        rd_en = 1'b1;
        tick(1'b0);
        rd_en = 1'b0;
        chk("empty_rd_count", 32'(count), 32'd0);
        chk("empty_rd_data", 32'(rd_data), 32'h00);
        for (int i = 0; i < 17; i++) capture(8'(i), 1'b0, 1'b0, 1'b0);
        chk("pre_clr_overrun", 32'(overrun), 32'd1);
        capture(8'h77, 1'b0, 1'b1, 1'b0);
        chk("clr_push_count", 32'(count), 32'd0);
        chk("clr_push_overrun", 32'(overrun), 32'd0);
        chk("clr_push_data", 32'(rd_data), 32'h00);

        // Async reset while the acknowledge is in flight
        capture(8'h21, 1'b0, 1'b0, 1'b0);
        rx_data = 8'h3C;
        rx_rs   = 1'b1;
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_over_read", 32'(rx_over_read), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_rd_data", 32'(rd_data), 32'h00);
        chk("arst_irq", 32'(irq), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0);
        tick(1'b0);
        chk("arst_no_early_push", 32'(count), 32'd0);
        tick(1'b1);
        chk("arst_recapture_count", 32'(count), 32'd1);
        chk("arst_recapture_data", 32'(rd_data), 32'h3C);
        tick(1'b0);
        rx_rs = 1'b0;
        repeat (3) tick(1'b0);

        // Randomized traffic against the queue model
        irq_level = 5'($urandom_range(0, 16));
        for (int n = 0; n < 150; n++) begin
            capture(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                for (int r = 0; r < int'($urandom_range(1, 6)); r++) begin
                    rd_en = 1'($urandom_range(0, 1));
                    tick(1'b0);
                end
                rd_en = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer directly downstream of the MiniUart receiver unit. Takes each completed byte from the receiver (`d_out`/`rs`), acknowledges it with a one-cycle `over_read` pulse, and queues it in a DEPTH-entry first-word-fall-through FIFO. The CPU/bridge side reads from the FIFO, so back-to-back frames are not lost while software is slow. The block also produces FIFO status, a sticky overrun flag and a level interrupt.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `AW`, log2(DEPTH): pointer width; count is AW+1 bits.

- `clk`  in  1: system clock; the same clock as the receiver unit.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rx_data`  in  8: receiver byte register (`d_out`).
- `rx_rs`  in  1: receiver byte-available flag (`rs`). Set from a derived clock, so it is treated as asynchronous.
- `rx_over_read`  out  1: to receiver `over_read`. Single-cycle high pulse, driven directly from a flop.
- `rd_en`  in  1: CPU pop strobe, one cycle per byte.
- `rd_data`  out  8: head entry (FWFT); 8'h00 when empty.
- `clr`  in  1: synchronous flush of the FIFO and `overrun`.
- `irq_level`  in  AW+1: interrupt threshold; 0 disables the level term.
- `count`  out  AW+1: current occupancy, 0..DEPTH.
- `empty`  out  1: count==0.
- `full`  out  1: count==DEPTH.
- `overrun`  out  1: sticky. Set when a byte is dropped because the FIFO is full.
- `irq`  out  1: registered; (irq_level!=0 && count>=irq_level) || overrun.

## Operation
- `rx_rs` passes through a 2-flop synchronizer to give `rs_s`.
- Capture FSM states: WAIT_RS, ACK, WAIT_CLR.
  - WAIT_RS: when `rs_s`=1, attempt a push of `rx_data`, then go to ACK.
  - ACK: `rx_over_read` is high for exactly this one cycle. Go to WAIT_CLR.
  - WAIT_CLR: stay until `rs_s`=0, then go to WAIT_RS. This prevents a double push of the same byte.
- `rx_data` is stable while `rx_rs`=1, because the receiver only shifts during the next frame. No data synchronizer is required.
- Push when not full, or when full with `rd_en` in the same cycle: write at `wr_ptr`, `wr_ptr`+1.
- Push when full without `rd_en`: the byte is dropped and `overrun` is set. The ACK is still issued so the receiver is freed.
- Pop: `rd_en` && !empty gives `rd_ptr`+1.
- `rd_en` on empty is ignored: no pointer or count change, no error.
- Simultaneous push and pop: both happen and `count` is unchanged.
- Pointers are AW bits and wrap modulo DEPTH.
- `count` increments on push only, decrements on pop only.
- `clr`: pointers and count go to 0 and `overrun` to 0.
  - `clr` has priority over a push or pop in the same cycle; the captured byte is discarded.
  - The FSM still proceeds normally, so the receiver is still acknowledged.
- `overrun` is cleared only by `clr` or reset.
- Reset values:
  - Pointers and count: 0.
  - `empty`=1, `full`=0, `overrun`=0, `irq`=0.
  - `rx_over_read`=0, `rd_data`=8'h00.
  - FSM: WAIT_RS; synchronizer flops: 0.
- Reset mid-handshake returns the FSM to WAIT_RS. If `rx_rs` is still high, the byte is captured again after reset; this is intended.

## Timing
- Edges are numbered from E1, the first `clk` edge that samples `rx_rs`=1.
  - E2: `rs_s`=1.
  - E3: push; `count`, `empty` and `full` update after E3.
  - `rx_over_read` is high from E3 to E4.
  - `irq` reflects the new count after E4 (one extra register stage).
- `rd_data` shows the new head combinationally from the memory at `rd_ptr`, the cycle after the pop edge.
- A first byte into an empty FIFO is visible on `rd_data` after E3.
- Minimum spacing between captures is 4 + (receiver clear latency) cycles. This is far below one frame time, so throughput is limited only by the line rate.

## Structure
- Package `uart_pkg`:
  - capture FSM state encoding (WAIT_RS=2'b00, ACK=2'b01, WAIT_CLR=2'b10);
  - default DEPTH;
  - the `HALF_BIT`-style shared UART constants already used elsewhere.
- Sub-module `sync_2ff` (1-bit, reset-to-0, async active-low reset) for `rx_rs`. It is reusable for `rxd`-side synchronization.
- Storage: an 8×DEPTH register array, inline, no reset on data.

## Test plan
1. **Single byte:** reset, then `rx_data`=8'hA5 with `rx_rs` raised at E1 → push at E3, a one-cycle `rx_over_read` at E3–E4, `rd_data`=8'hA5, `count`=1, `empty`=0.
2. **Fill and overrun:** 17 bytes 8'h00..8'h10 with no reads, DEPTH=16 → `full`=1 after the 16th. The 17th is dropped but still acknowledged; `overrun`=1 and `irq`=1. Reading 16 bytes returns 8'h00..8'h0F in order.
3. **Push/pop at full:** with `rd_en` asserted on the push edge → `count` stays 16, `overrun`=0, and order is preserved across pointer wrap.
4. **Threshold interrupt:** `irq_level`=4 → `irq` rises after the 4th push (one cycle after the count update) and falls after the pop to 3. With `irq_level`=0, `irq` stays 0.
5. **Empty read and clear:**
   - `rd_en` on empty → no change, `rd_data`=8'h00.
   - `clr` in the same cycle as a push → `count`=0, `overrun`=0, byte discarded, `rx_over_read` still pulsed.
6. **Async reset mid-handshake:** `rst_n` low during ACK → all outputs go to their reset values immediately. With `rx_rs` held high, the byte is re-captured 3 edges after `rst_n` deasserts.
